// File: rtl/mod_n_counter_pkg.sv
// ============================================================================
// Module      : mod_n_counter_pkg
// Description : Shared direction constants and sizing helper for counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mod_n_counter_pkg;

    localparam logic c_DIR_UP   = 1'b1;
    localparam logic c_DIR_DOWN = 1'b0;

    // Bits needed to hold the values 0..value-1 (minimum 1).
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mod_n_counter_next.sv
// ============================================================================
// Module      : counter_next
// Description : Combinational next-state mux chain for the modulo-N counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_next
    import mod_n_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] nextQ,
    output logic             nextErr,
    output logic             tc
);

    // Range compare is WIDTH+1 bits wide so MODULUS == 2**WIDTH is representable.
    localparam logic [WIDTH:0]   c_MOD_X = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] c_MAX_Q = WIDTH'(MODULUS - 1);

    logic             w_qIsMax;
    logic             w_qIsZero;
    logic             w_dInRange;
    logic [WIDTH-1:0] w_stepUp;
    logic [WIDTH-1:0] w_stepDown;
    logic [WIDTH-1:0] w_afterEn;
    logic [WIDTH-1:0] w_loadVal;
    logic [WIDTH-1:0] w_afterLoad;

    assign w_qIsMax   = (q == c_MAX_Q);
    assign w_qIsZero  = (q == '0);
    assign w_dInRange = ({1'b0, d} < c_MOD_X);

    assign w_stepUp    = w_qIsMax  ? '0      : q + WIDTH'(1);
    assign w_stepDown  = w_qIsZero ? c_MAX_Q : q - WIDTH'(1);
    assign w_afterEn   = en ? ((up == c_DIR_UP) ? w_stepUp : w_stepDown) : q;
    assign w_loadVal   = w_dInRange ? d : c_MAX_Q;
    assign w_afterLoad = load ? w_loadVal : w_afterEn;
    assign nextQ       = clr ? '0 : w_afterLoad;

    assign nextErr = ~clr & load & ~w_dInRange;
    assign tc      = ((up == c_DIR_UP) & w_qIsMax) | ((up == c_DIR_DOWN) & w_qIsZero);

endmodule

`default_nettype wire

// File: rtl/mod_n_counter.sv
// ============================================================================
// Module      : mod_n_counter
// Description : Parametrised modulo-N up/down counter with load and cascade.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_n_counter
    import mod_n_counter_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int MODULUS     = 10,
    parameter int RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             up,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             carry_out,
    output logic             load_err
);

    generate
        if (WIDTH < 1 || WIDTH > 30 || MODULUS < 2 || MODULUS > (1 << WIDTH) ||
            RESET_VALUE < 0 || RESET_VALUE >= MODULUS) begin : g_badParams
            $error("mod_n_counter: illegal WIDTH/MODULUS/RESET_VALUE combination");
        end
    endgenerate

    localparam logic [WIDTH-1:0] c_RESET_Q = WIDTH'(RESET_VALUE);

    // Register bank holds {load_err, q}.
    logic [WIDTH:0]   r_bank;
    logic [WIDTH-1:0] w_nextQ;
    logic             w_nextErr;
    logic             w_tc;

    counter_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .q       (r_bank[WIDTH-1:0]),
        .up      (up),
        .en      (en),
        .clr     (clr),
        .load    (load),
        .d       (d),
        .nextQ   (w_nextQ),
        .nextErr (w_nextErr),
        .tc      (w_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bank <= {1'b0, c_RESET_Q};
        end else begin
            r_bank <= {w_nextErr, w_nextQ};
        end
    end

    assign q         = r_bank[WIDTH-1:0];
    assign load_err  = r_bank[WIDTH];
    assign tc        = w_tc;
    assign carry_out = en & w_tc & ~clr & ~load & rst_n;

endmodule

`default_nettype wire

// File: tb/tb_mod_n_counter.sv
// ============================================================================
// Module      : tb_mod_n_counter
// Description : Directed self-checking bench for mod_n_counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mod_n_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Main decade instance plus a RESET_VALUE=3 twin sharing its inputs.
    logic       rstN = 1'b0, en = 1'b0, clr = 1'b0, load = 1'b0, up = 1'b1;
    logic [3:0] d = 4'd0;
    logic [3:0] q, qR;
    logic       tc, carryOut, loadErr, tcR, carryOutR, loadErrR;

    mod_n_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) dutA (
        .clk(clk), .rst_n(rstN), .en(en), .clr(clr), .load(load), .d(d), .up(up),
        .q(q), .tc(tc), .carry_out(carryOut), .load_err(loadErr));

    mod_n_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(3)) dutR (
        .clk(clk), .rst_n(rstN), .en(en), .clr(clr), .load(load), .d(d), .up(up),
        .q(qR), .tc(tcR), .carry_out(carryOutR), .load_err(loadErrR));

    // Two-digit cascade.
    logic       cRstN = 1'b0, cEn = 1'b0;
    logic [3:0] qLo, qHi;
    logic       tcLo, coLo, errLo, tcHi, coHi, errHi;

    mod_n_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) dutLo (
        .clk(clk), .rst_n(cRstN), .en(cEn), .clr(1'b0), .load(1'b0), .d(4'd0), .up(1'b1),
        .q(qLo), .tc(tcLo), .carry_out(coLo), .load_err(errLo));

    mod_n_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) dutHi (
        .clk(clk), .rst_n(cRstN), .en(coLo), .clr(1'b0), .load(1'b0), .d(4'd0), .up(1'b1),
        .q(qHi), .tc(tcHi), .carry_out(coHi), .load_err(errHi));

    // Power-of-two modulus instance.
    logic       pRstN = 1'b0, pEn = 1'b0, pLoad = 1'b0;
    logic [2:0] pD = 3'd0;
    logic [2:0] qP;
    logic       tcP, coP, errP;

    mod_n_counter #(.WIDTH(3), .MODULUS(8), .RESET_VALUE(0)) dutP (
        .clk(clk), .rst_n(pRstN), .en(pEn), .clr(1'b0), .load(pLoad), .d(pD), .up(1'b1),
        .q(qP), .tc(tcP), .carry_out(coP), .load_err(errP));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        tick();
        tick();
        checks++;
        if (q !== 4'd0 || loadErr !== 1'b0) begin
            errors++;
            $display("FAIL reset_a: q=%0d err=%b, required q=0 err=0", q, loadErr);
        end
        checks++;
        if (qR !== 4'd3) begin
            errors++;
            $display("FAIL reset_value: q=%0d, required 3", qR);
        end
    endtask

    task automatic test_up_wrap();
        logic [3:0] exp;
        rstN = 1'b1;
        en   = 1'b1;
        up   = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            tick();
            exp = 4'(n % 10);
            checks++;
            if (q !== exp || tc !== (exp == 4'd9) || carryOut !== (exp == 4'd9)) begin
                errors++;
                $display("FAIL up_wrap[%0d]: q=%0d tc=%b co=%b, required q=%0d tc=co=%b",
                         n, q, tc, carryOut, exp, (exp == 4'd9));
            end
        end
    endtask

    task automatic test_down_wrap();
        logic [3:0] expSeq [4];
        expSeq = '{4'd1, 4'd0, 4'd9, 4'd8};
        up = 1'b0;
        for (int n = 0; n < 4; n++) begin
            tick();
            checks++;
            if (q !== expSeq[n] || tc !== (expSeq[n] == 4'd0)) begin
                errors++;
                $display("FAIL down_wrap[%0d]: q=%0d tc=%b, required q=%0d tc=%b",
                         n, q, tc, expSeq[n], (expSeq[n] == 4'd0));
            end
        end
        // Direction change: from 8, count up once -> 9, then down once -> 8.
        up = 1'b1;
        tick();
        up = 1'b0;
        tick();
        checks++;
        if (q !== 4'd8) begin
            errors++;
            $display("FAIL dir_change: q=%0d, required 8", q);
        end
    endtask

    task automatic test_load();
        en   = 1'b0;
        load = 1'b1;
        d    = 4'd7;
        tick();
        checks++;
        if (q !== 4'd7 || loadErr !== 1'b0) begin
            errors++;
            $display("FAIL load_7: q=%0d err=%b, required q=7 err=0", q, loadErr);
        end
        d = 4'd12;
        tick();
        checks++;
        if (q !== 4'd9 || loadErr !== 1'b1) begin
            errors++;
            $display("FAIL load_12: q=%0d err=%b, required q=9 err=1", q, loadErr);
        end
        load = 1'b0;
        tick();
        checks++;
        if (q !== 4'd9 || loadErr !== 1'b0) begin
            errors++;
            $display("FAIL load_err_pulse: q=%0d err=%b, required q=9 err=0", q, loadErr);
        end
        load = 1'b1;
        d    = 4'd10;
        tick();
        checks++;
        if (q !== 4'd9 || loadErr !== 1'b1) begin
            errors++;
            $display("FAIL load_10: q=%0d err=%b, required q=9 err=1", q, loadErr);
        end
        d = 4'd9;
        tick();
        checks++;
        if (q !== 4'd9 || loadErr !== 1'b0) begin
            errors++;
            $display("FAIL load_9: q=%0d err=%b, required q=9 err=0", q, loadErr);
        end
    endtask

    task automatic test_priority();
        // q=9, counting up: tc is high, but load masks carry_out.
        load = 1'b1;
        en   = 1'b1;
        up   = 1'b1;
        d    = 4'd3;
        #1;
        checks++;
        if (tc !== 1'b1 || carryOut !== 1'b0) begin
            errors++;
            $display("FAIL load_masks_co: tc=%b co=%b, required tc=1 co=0", tc, carryOut);
        end
        clr  = 1'b1;
        load = 1'b0;
        d    = 4'd12;
        #1;
        checks++;
        if (carryOut !== 1'b0) begin
            errors++;
            $display("FAIL clr_masks_co: co=%b, required 0", carryOut);
        end
        load = 1'b1;
        tick();
        checks++;
        if (q !== 4'd0 || loadErr !== 1'b0 || carryOut !== 1'b0) begin
            errors++;
            $display("FAIL clr_priority: q=%0d err=%b co=%b, required q=0 err=0 co=0",
                     q, loadErr, carryOut);
        end
        // Reset beats load; down-count at q=0 gives tc=1 but rst_n masks carry_out.
        clr  = 1'b0;
        rstN = 1'b0;
        up   = 1'b0;
        d    = 4'd5;
        #1;
        checks++;
        if (tc !== 1'b1 || carryOut !== 1'b0) begin
            errors++;
            $display("FAIL rst_masks_co: tc=%b co=%b, required tc=1 co=0", tc, carryOut);
        end
        tick();
        checks++;
        if (q !== 4'd0 || qR !== 4'd3 || loadErr !== 1'b0) begin
            errors++;
            $display("FAIL rst_priority: q=%0d qR=%0d err=%b, required q=0 qR=3 err=0",
                     q, qR, loadErr);
        end
        load = 1'b0;
        en   = 1'b0;
        rstN = 1'b1;
    endtask

    task automatic test_cascade();
        logic [3:0] expLo, expHi;
        cRstN = 1'b0;
        tick();
        cRstN = 1'b1;
        cEn   = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            tick();
            expLo = 4'(n % 10);
            expHi = 4'((n / 10) % 10);
            checks++;
            if (qLo !== expLo || qHi !== expHi) begin
                errors++;
                $display("FAIL cascade[%0d]: pair=%0d%0d, required %0d%0d",
                         n, qHi, qLo, expHi, expLo);
            end
        end
        cEn = 1'b0;
    endtask

    task automatic test_pow2();
        logic [2:0] exp;
        pRstN = 1'b0;
        tick();
        pRstN = 1'b1;
        pEn   = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            tick();
            exp = 3'(n % 8);
            checks++;
            if (qP !== exp) begin
                errors++;
                $display("FAIL pow2[%0d]: q=%0d, required %0d", n, qP, exp);
            end
        end
        pEn   = 1'b0;
        pLoad = 1'b1;
        pD    = 3'd7;
        tick();
        checks++;
        if (qP !== 3'd7 || errP !== 1'b0) begin
            errors++;
            $display("FAIL pow2_load: q=%0d err=%b, required q=7 err=0", qP, errP);
        end
        pLoad = 1'b0;
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_load();
        test_priority();
        test_cascade();
        test_pow2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
